// File: rtl/mul_float_arb_pkg.sv
// mul_float_arb_pkg: shared constants and the round-robin pick function
// for the float multiplier request arbiter.
package mul_float_arb_pkg;

  localparam int FLOAT_W    = 32;
  localparam int STAT_CNT_W = 16;

  // rr_pick works on a fixed 8-wide request vector so one function serves
  // every REQ_N in 2..8. Callers zero-pad the unused upper requests.
  localparam int RR_MAX_N = 8;
  localparam int RR_ID_W  = 3;

  // Pick the first active request after 'last', wrapping modulo n.
  // If nothing is requesting, 'last' is returned; callers ignore the
  // result in that case.
  function automatic logic [RR_ID_W-1:0] rr_pick(
    input logic [RR_MAX_N-1:0] req,
    input logic [RR_ID_W-1:0]  last,
    input int                  n
  );
    logic [RR_ID_W-1:0] pick;
    logic               found;
    int                 idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= RR_MAX_N; k++) begin
      idx = (int'(last) + k) % n;
      if (!found && (k <= n) && req[RR_ID_W'(idx)]) begin
        pick  = RR_ID_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mul_float_arb_tag_fifo.sv
// mul_float_arb_tag_fifo: in-order FIFO of requester IDs.
// One entry is pushed for every issued operation and popped when the
// matching product is handed back. The head is read combinationally,
// because the return path must route the product in the same cycle.
module mul_float_arb_tag_fifo
  import mul_float_arb_pkg::*;
#(
  parameter int TAG_W = 2,
  parameter int DEPTH = 8
) (
  input  logic             iCLOCK,
  input  logic             iRESET,
  input  logic             iRESET_SYNC,
  input  logic             iPUSH,
  input  logic [TAG_W-1:0] iPUSH_TAG,
  input  logic             iPOP,
  output logic [TAG_W-1:0] oHEAD,
  output logic             oFULL,
  output logic             oEMPTY
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [TAG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  // Full and empty come from the occupancy count; the pointers wrap freely.
  assign oFULL   = (count_reg == CNT_W'(DEPTH));
  assign oEMPTY  = (count_reg == '0);
  assign do_push = iPUSH && !oFULL;
  assign do_pop  = iPOP && !oEMPTY;
  assign oHEAD   = mem[rd_ptr_reg];

  // Tag storage: no reset needed, the contents are only read when non-empty.
  always_ff @(posedge iCLOCK) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= iPUSH_TAG;
    end
  end

  // Pointers and occupancy. Either reset discards every tag in flight.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (iRESET_SYNC) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mul_float_req_arbiter.sv
// mul_float_req_arbiter: shares one pipelined float multiplier among REQ_N
// requesters. Issue slots are granted round-robin, the requester ID of each
// issued operation is queued in order, and every returning product is routed
// to the requester at the head of that queue.
// Optional feature: define MUL_FLOAT_ARB_STATS_EN to add oSTAT_GRANT, one
// 16-bit saturating issue counter per requester.
module mul_float_req_arbiter
  import mul_float_arb_pkg::*;
#(
  parameter int REQ_N     = 4,
  parameter int TAG_DEPTH = 8
) (
  input  logic                       iCLOCK,
  input  logic                       iRESET,
  input  logic                       iRESET_SYNC,
  input  logic [REQ_N-1:0]           iREQ_VALID,
  output logic [REQ_N-1:0]           oREQ_BUSY,
  input  logic [FLOAT_W*REQ_N-1:0]   iREQ_DATA_A,
  input  logic [FLOAT_W*REQ_N-1:0]   iREQ_DATA_B,
  output logic                       oMUL_VALID,
  input  logic                       iMUL_BUSY,
  output logic [FLOAT_W-1:0]         oMUL_DATA_A,
  output logic [FLOAT_W-1:0]         oMUL_DATA_B,
  input  logic                       iMUL_VALID,
  output logic                       oMUL_BUSY,
  input  logic [FLOAT_W-1:0]         iMUL_DATA,
  output logic [REQ_N-1:0]           oRES_VALID,
  input  logic [REQ_N-1:0]           iRES_BUSY,
  output logic [FLOAT_W-1:0]         oRES_DATA,
  output logic                       oERR_UNDERFLOW
`ifdef MUL_FLOAT_ARB_STATS_EN
  ,
  output logic [STAT_CNT_W*REQ_N-1:0] oSTAT_GRANT
`endif
);

  localparam int TAG_W = $clog2(REQ_N);

  logic                clear;
  logic                req_any;
  logic                fifo_full;
  logic                fifo_empty;
  logic [TAG_W-1:0]    head;
  logic [TAG_W-1:0]    last_grant_reg;
  logic [TAG_W-1:0]    grant;
  logic [RR_MAX_N-1:0] req_pad;
  logic [RR_ID_W-1:0]  last_pad;
  logic [RR_ID_W-1:0]  grant_wide;
  logic                issue;
  logic                ret_valid;
  logic                ret_done;
  logic                underflow_reg;

  // A clearing reset blocks issue and return so no tag is half-recorded.
  assign clear   = iRESET || iRESET_SYNC;
  assign req_any = |iREQ_VALID;

  // Round-robin search starting after the last completed grant.
  always_comb begin
    req_pad                 = '0;
    req_pad[REQ_N-1:0]      = iREQ_VALID;
    last_pad                = '0;
    last_pad[TAG_W-1:0]     = last_grant_reg;
    grant_wide              = rr_pick(req_pad, last_pad, REQ_N);
  end
  assign grant = grant_wide[TAG_W-1:0];

  // oMUL_VALID ignores the multiplier stall; issue needs it clear as well.
  assign oMUL_VALID = req_any && !fifo_full && !clear;
  assign issue      = oMUL_VALID && !iMUL_BUSY;

  // Forward the granted requester's operands.
  always_comb begin
    oMUL_DATA_A = iREQ_DATA_A[FLOAT_W-1:0];
    oMUL_DATA_B = iREQ_DATA_B[FLOAT_W-1:0];
    for (int i = 0; i < REQ_N; i++) begin
      if (grant == TAG_W'(i)) begin
        oMUL_DATA_A = iREQ_DATA_A[i*FLOAT_W +: FLOAT_W];
        oMUL_DATA_B = iREQ_DATA_B[i*FLOAT_W +: FLOAT_W];
      end
    end
  end

  // Return path: the head tag selects which requester sees the product.
  assign ret_valid = iMUL_VALID && !fifo_empty && !clear;
  assign oMUL_BUSY = ret_valid && iRES_BUSY[head];
  assign ret_done  = ret_valid && !iRES_BUSY[head];
  assign oRES_DATA = iMUL_DATA;

  genvar gi;
  generate
    for (gi = 0; gi < REQ_N; gi++) begin : g_req
      assign oREQ_BUSY[gi]  = !(issue && (grant == TAG_W'(gi)));
      assign oRES_VALID[gi] = ret_valid && (head == TAG_W'(gi));
    end
  endgenerate

  mul_float_arb_tag_fifo #(
    .TAG_W (TAG_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .iCLOCK      (iCLOCK),
    .iRESET      (iRESET),
    .iRESET_SYNC (iRESET_SYNC),
    .iPUSH       (issue),
    .iPUSH_TAG   (grant),
    .iPOP        (ret_done),
    .oHEAD       (head),
    .oFULL       (fifo_full),
    .oEMPTY      (fifo_empty)
  );

  // Last grant advances only on a completed issue; REQ_N-1 makes requester 0 first.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      last_grant_reg <= TAG_W'(REQ_N - 1);
    end else if (iRESET_SYNC) begin
      last_grant_reg <= TAG_W'(REQ_N - 1);
    end else if (issue) begin
      last_grant_reg <= grant;
    end
  end

  // Sticky flag for a product arriving with no tag in flight; that product is dropped.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      underflow_reg <= 1'b0;
    end else if (iRESET_SYNC) begin
      underflow_reg <= 1'b0;
    end else if (iMUL_VALID && fifo_empty) begin
      underflow_reg <= 1'b1;
    end
  end
  assign oERR_UNDERFLOW = underflow_reg;

`ifdef MUL_FLOAT_ARB_STATS_EN
  generate
    for (gi = 0; gi < REQ_N; gi++) begin : g_stat
      logic [STAT_CNT_W-1:0] cnt_reg;
      // Saturating count of issues granted to this requester.
      always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
          cnt_reg <= '0;
        end else if (iRESET_SYNC) begin
          cnt_reg <= '0;
        end else if (issue && (grant == TAG_W'(gi)) && (cnt_reg != '1)) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
      assign oSTAT_GRANT[gi*STAT_CNT_W +: STAT_CNT_W] = cnt_reg;
    end
  endgenerate
`endif

endmodule
